// File: rtl/rotor_return_path_pkg.sv
// Shared types and constants for the rotor return path: letter/position widths
// and the fixed rotor wiring table used by both forward and return rotors.
package rotor_return_path_pkg;

    localparam int LETTER_W = 26;
    localparam int POS_W    = 5;
    localparam int MOD      = 26;

    typedef logic [LETTER_W-1:0] letter_t;
    typedef logic [POS_W-1:0]    pos_t;

    // Forward wiring: forward out[i] = x[WIRING[i]]
    localparam pos_t WIRING [MOD] = '{
        5'd17, 5'd20, 5'd12, 5'd23, 5'd9,  5'd10, 5'd5,  5'd18, 5'd25,
        5'd3,  5'd11, 5'd4,  5'd19, 5'd7,  5'd21, 5'd6,  5'd13, 5'd15,
        5'd24, 5'd1,  5'd16, 5'd0,  5'd8,  5'd14, 5'd2,  5'd22
    };

    function automatic pos_t pos_inc(input pos_t p);
        return (p == pos_t'(MOD - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/rotor_return_path_if.sv
// Letter stream into and out of the return path: valid/ready on both sides,
// plus the error flag that qualifies the outgoing letter.
interface rotor_return_path_if;
    import rotor_return_path_pkg::*;

    logic    in_valid;
    logic    in_ready;
    letter_t in_letter;
    logic    out_valid;
    logic    out_ready;
    letter_t out_letter;
    logic    out_err;

    modport master (
        output in_valid, in_letter, out_ready,
        input  in_ready, out_valid, out_letter, out_err
    );

    modport slave (
        input  in_valid, in_letter, out_ready,
        output in_ready, out_valid, out_letter, out_err
    );

endinterface

// File: rtl/rotor_return_path_inverse_mapping.sv
// Pure combinational inverse of the rotor wiring at position zero: b = F^-1(a).
module inverse_mapping
    import rotor_return_path_pkg::*;
(
    input  letter_t a,
    output letter_t b
);

    always_comb begin
        b = '0;
        for (int i = 0; i < MOD; i++) begin
            b[WIRING[i]] = a[i];
        end
    end

endmodule

// File: rtl/rotor_return_path.sv
// Return path through one rotor: position-offset inverse wiring, a one-deep
// registered valid/ready output stage, and the position/notch counter.
module rotor_return_path
    import rotor_return_path_pkg::*;
#(
    parameter pos_t NOTCH_POS = 5'd16,
    parameter pos_t RESET_POS = 5'd0
) (
    input  logic clk,
    input  logic reset,
    input  logic step,
    input  logic load_en,
    input  pos_t load_pos,
    output pos_t position,
    output logic notch_out,
    rotor_return_path_if.slave bus
);

    letter_t a_rot;
    letter_t b_map;
    letter_t r_rot;
    logic    [5:0] back_shift;
    logic    in_err;
    logic    accept;
    logic    out_valid_q;
    letter_t out_letter_q;
    logic    out_err_q;

    // Rotate into the rotor's frame, apply the fixed inverse, rotate back out
    assign a_rot      = letter_t'({bus.in_letter, bus.in_letter} >> position);
    assign back_shift = 6'(MOD) - {1'b0, position};
    assign r_rot      = letter_t'({b_map, b_map} >> back_shift);

    inverse_mapping u_inverse_mapping (
        .a (a_rot),
        .b (b_map)
    );

    assign in_err = ($countones(bus.in_letter) != 1);

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_letter = out_letter_q;
    assign bus.out_err    = out_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_letter_q <= '0;
            out_err_q    <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_letter_q <= in_err ? '0 : r_rot;
            out_err_q    <= in_err;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    // Out-of-range load values fall back to position zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            position  <= RESET_POS;
            notch_out <= 1'b0;
        end else begin
            notch_out <= step && !load_en && (position == NOTCH_POS);
            if (load_en) begin
                position <= (load_pos > pos_t'(MOD - 1)) ? '0 : load_pos;
            end else if (step) begin
                position <= pos_inc(position);
            end
        end
    end

endmodule

// File: tb/tb_rotor_return_path.sv
// Self-checking bench for rotor_return_path: directed vectors with literal
// expectations plus a per-cycle compare against an arithmetic letter/position model.
module tb_rotor_return_path;
    import rotor_return_path_pkg::*;

    localparam logic [4:0] TB_NOTCH = 5'd16;
    localparam logic [4:0] TB_RESET = 5'd0;

    logic clk = 1'b0;
    logic rst;
    logic step;
    logic load_en;
    logic [4:0] load_pos;
    logic [4:0] position;
    logic notch_out;

    rotor_return_path_if bus ();

    rotor_return_path #(.NOTCH_POS(TB_NOTCH), .RESET_POS(TB_RESET)) dut (
        .clk       (clk),
        .reset     (rst),
        .step      (step),
        .load_en   (load_en),
        .load_pos  (load_pos),
        .position  (position),
        .notch_out (notch_out),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int fwd [26] = '{17, 20, 12, 23, 9, 10, 5, 18, 25, 3, 11, 4, 19,
                     7, 21, 6, 13, 15, 24, 1, 16, 0, 8, 14, 2, 22};

    typedef struct {
        logic [25:0] letter;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   mpos;
    logic mnotch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Letter k entering at position s leaves as (F[(k-s) mod 26] + s) mod 26
    function automatic logic [25:0] model_letter(input logic [25:0] x, input int s);
        int k;
        logic [25:0] res;
        k = 0;
        for (int i = 0; i < 26; i++) if (x[i]) k = i;
        res = '0;
        if ($countones(x) == 1) res[(fwd[(k - s + 26) % 26] + s) % 26] = 1'b1;
        return res;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("rst_position", {27'd0, position}, {27'd0, TB_RESET});
            chk("rst_notch", {31'd0, notch_out}, 32'd0);
            q.delete();
            mpos   = int'(TB_RESET);
            mnotch = 1'b0;
        end else begin
            int   qn;
            exp_t e;
            qn = q.size();
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, qn != 0});
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (qn == 0) || bus.out_ready});
            if (qn != 0) begin
                chk("out_letter", {6'd0, bus.out_letter}, {6'd0, q[0].letter});
                chk("out_err", {31'd0, bus.out_err}, {31'd0, q[0].err});
            end
            chk("position", {27'd0, position}, mpos);
            chk("notch_out", {31'd0, notch_out}, {31'd0, mnotch});
            if (qn != 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && (qn == 0 || bus.out_ready)) begin
                e.letter = model_letter(bus.in_letter, mpos);
                e.err    = ($countones(bus.in_letter) != 1);
                q.push_back(e);
            end
            mnotch = step && !load_en && (mpos == int'(TB_NOTCH));
            if (load_en) mpos = (load_pos > 5'd25) ? 0 : int'(load_pos);
            else if (step) mpos = (mpos + 1) % 26;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] p);
        load_en  = 1'b1;
        load_pos = p;
        tick();
        load_en  = 1'b0;
    endtask

    task automatic send(input logic [25:0] x);
        bus.in_valid  = 1'b1;
        bus.in_letter = x;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; step = 1'b0; load_en = 1'b0; load_pos = '0;
        bus.in_valid = 1'b0; bus.in_letter = '0; bus.out_ready = 1'b1;
        tick(); tick();
        chk("reset_out_letter", {6'd0, bus.out_letter}, 32'd0);
        chk("reset_out_err", {31'd0, bus.out_err}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: A at position 0 -> R
        send(26'h0000001);
        chk("t1_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_letter", {6'd0, bus.out_letter}, 32'h0020000);
        chk("t1_err", {31'd0, bus.out_err}, 32'd0);
        tick();

        // 2: B at position 1 -> S
        load(5'd1);
        chk("t2_pos", {27'd0, position}, 32'd1);
        send(26'h0000002);
        chk("t2_letter", {6'd0, bus.out_letter}, 32'h0040000);
        tick();

        // 3: notch at 16, wrap at 25, load priority and clamp
        load(5'd16);
        step = 1'b1; tick(); step = 1'b0;
        chk("t3_pos17", {27'd0, position}, 32'd17);
        chk("t3_notch_hi", {31'd0, notch_out}, 32'd1);
        tick();
        chk("t3_notch_lo", {31'd0, notch_out}, 32'd0);
        load(5'd25);
        step = 1'b1; tick(); step = 1'b0;
        chk("t3_wrap", {27'd0, position}, 32'd0);
        chk("t3_wrap_notch", {31'd0, notch_out}, 32'd0);
        step = 1'b1; load(5'd5); step = 1'b0;
        chk("t3_load_prio", {27'd0, position}, 32'd5);
        load(5'd30);
        chk("t3_clamp", {27'd0, position}, 32'd0);

        // 4: backpressure holds A, then A and B drain in order
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_letter = 26'h0000001;
        tick();
        bus.in_letter = 26'h0000002;
        chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("t4_hold_letter", {6'd0, bus.out_letter}, 32'h0020000);
        chk("t4_hold_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t4_second", {6'd0, bus.out_letter}, 32'h0100000);
        tick();
        chk("t4_drained", {31'd0, bus.out_valid}, 32'd0);

        // 5: malformed letters
        send(26'h0000003);
        chk("t5_two_letter", {6'd0, bus.out_letter}, 32'd0);
        chk("t5_two_err", {31'd0, bus.out_err}, 32'd1);
        send(26'h0000000);
        chk("t5_zero_err", {31'd0, bus.out_err}, 32'd1);
        tick();

        // Streaming mix with steps, a load and intermittent backpressure
        for (int i = 0; i < 40; i++) begin
            bus.in_valid  = (i % 5 != 2);
            bus.in_letter = (i % 11 == 5) ? 26'h0000300 : 26'd1 << ((i * 7) % 26);
            step          = (i % 3 == 0);
            load_en       = (i == 20);
            load_pos      = 5'd24;
            bus.out_ready = (i % 4 != 3);
            tick();
        end
        bus.in_valid = 1'b0; step = 1'b0; load_en = 1'b0; bus.out_ready = 1'b1;
        tick(); tick();

        // 6: async reset while a letter is held at position 9
        load(5'd9);
        bus.out_ready = 1'b0;
        send(26'h0000001);
        chk("t6_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_async_pos", {27'd0, position}, {27'd0, TB_RESET});
        chk("t6_async_letter", {6'd0, bus.out_letter}, 32'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        send(26'h0000001);
        chk("t6_after_letter", {6'd0, bus.out_letter}, 32'h0020000);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
